carregador_matriz: RTL and testbench
====================================

# carregador_matriz

Serial-to-parallel matrix loader that sits directly upstream of the transposition stage. It accepts signed 8-bit elements one per handshake in row-major order, places each at packed slot `row*5+col` of a 200-bit 5x5 frame, and zero-fills unused slots. It then presents the complete frame with `matrix_size` through a valid/ready handshake to the transposer and the other operation units.

## Interface
Parameters:
- none. The frame is fixed at 5x5 elements, 8 bits each, 200 bits total.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begins a load. Honoured only in IDLE.
- `matrix_size_in`  in  2  00 = 2x2, 01 = 3x3, 10 = 4x4, 11 = 5x5. Sampled on an accepted `start`.
- `in_data`  in  8  signed element.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  loader accepts an element this cycle.
- `matrix_A`  out  200  signed packed frame. Element (r,c) sits at bits `[(r*5+c)*8 +: 8]`.
- `matrix_size`  out  2  latched size code, forwarded with the frame.
- `out_valid`  out  1  frame complete and stable.
- `out_ready`  in  1  downstream consumes the frame.
- `busy`  out  1  high in LOAD or DONE.

## Operation
FSM states: IDLE, LOAD, DONE.

**IDLE**
- `in_ready` = 0, `out_valid` = 0.
- On `start` = 1:
  - latch `matrix_size_in` into `matrix_size`;
  - set N = code + 2;
  - clear `matrix_A` to 0;
  - set row = col = 0;
  - go to LOAD.

**LOAD**
- `in_ready` = 1 (combinational from state).
- Each cycle with `in_valid` & `in_ready`:
  - write `in_data` to slot `row*5+col`;
  - if col == N-1: col = 0 and row++; else col++.
- When the element written is (N-1, N-1), go to DONE.
- `start` is ignored.

**DONE**
- `out_valid` = 1.
- `matrix_A` and `matrix_size` are held constant.
- On `out_ready` = 1, go to IDLE (`out_valid` falls the next cycle).
- `in_ready` = 0, so `in_data` is ignored.
- `start` is ignored in DONE. A new load needs a `start` while in IDLE, at the earliest the cycle after the handshake.

**Data and packing rules**
- Elements are stored bit-exact. There is no sign extension or arithmetic.
- Slots with row ≥ N or col ≥ N stay 0.
- Packing pitch is always 5, whatever N is. Example: a 3x3 load writes slots 0, 1, 2, 5, 6, 7, 10, 11, 12.
- The row/col counters are 3 bits each. They never exceed 4 and do not wrap past N-1.

**Reset**
- `rst` is synchronous and overrides everything, including mid-LOAD and mid-DONE.
- All outputs and internal state go to reset values on the next rising edge. The partial frame is discarded.

**Reset values**
- state = IDLE
- `matrix_A` = 0
- `matrix_size` = 00
- `out_valid` = 0
- `in_ready` = 0
- `busy` = 0
- row = col = 0

## Timing
- `start` accepted at edge k → LOAD from cycle k+1, with `in_ready` = 1 in cycle k+1.
- Input throughput: one element per cycle when `in_valid` is held high.
- Last element accepted at edge m → `out_valid` = 1 from cycle m+1, with `matrix_A` already containing that element.
- Minimum load for N×N: `start` cycle + N² cycles. `out_valid` rises N²+1 cycles after the `start` edge.
  - 2x2: 5 cycles.
  - 5x5: 26 cycles.
- `in_valid` low in LOAD: counters and data hold (stall). There is no timeout.
- Simultaneous `out_valid` & `out_ready` at edge p → IDLE at p+1, `out_valid` = 0 at p+1.
- `out_ready` held high before DONE: the handshake completes in the first DONE cycle, so `out_valid` lasts exactly 1 cycle.
- `rst` together with any other event: `rst` wins.

## Test plan
1. **Reset values.** `rst` = 1 for 2 cycles, then release → `matrix_A` = 0, `out_valid` = 0, `in_ready` = 0, `busy` = 0.
2. **2x2 load, continuous input.** `start` with size 00, then elements 1, 2, 3, 4 back-to-back with `out_ready` = 0 →
   - `out_valid` rises 5 cycles after the `start` edge;
   - bytes 0 = 1, 1 = 2, 5 = 3, 6 = 4; all other bytes 0;
   - frame held stable for 10 cycles until `out_ready` pulses, then IDLE.
3. **5x5 signed, with stalls.** `start` with size 11; send elements -128..-104 (0x80..0x98) with `in_valid` deasserted on every third cycle →
   - all 25 bytes match in row-major order;
   - `out_valid` rises exactly one cycle after the 25th accept;
   - no element is lost or duplicated.
4. **3x3 with stale data.** Load 3x3 values 10..18 after a prior 5x5 frame of 0xFF → bytes 0–2 = 10–12, 5–7 = 13–15, 10–12 = 16–18; every other byte 0 (no stale 0xFF).
5. **Ignored inputs.**
   - `start` pulsed during LOAD and during DONE → no restart, counters undisturbed.
   - `in_valid` during DONE with `in_data` = 0x55 → `matrix_A` unchanged.
6. **Reset mid-load.** Assert `rst` after 2 of 9 elements of a 3x3 load → next cycle in IDLE with `matrix_A` = 0. A fresh 2x2 load then completes correctly with `matrix_size` = 00.

Source files
------------

// File: rtl/carregador_matriz_if.sv
// Handshake bundle between the element source, the matrix loader and the
// downstream transposer / operation units.
interface carregador_matriz_if;
    logic               start;
    logic [1:0]         matrix_size_in;
    logic signed [7:0]  in_data;
    logic               in_valid;
    logic               in_ready;
    logic signed [199:0] matrix_A;
    logic [1:0]         matrix_size;
    logic               out_valid;
    logic               out_ready;
    logic               busy;

    modport master (
        output start, matrix_size_in, in_data, in_valid, out_ready,
        input  in_ready, matrix_A, matrix_size, out_valid, busy
    );

    modport slave (
        input  start, matrix_size_in, in_data, in_valid, out_ready,
        output in_ready, matrix_A, matrix_size, out_valid, busy
    );
endinterface

// File: rtl/carregador_matriz.sv
// Serial-to-parallel loader: packs row-major signed bytes into a zero-filled
// 5x5 frame (pitch 5) and hands the frame downstream via valid/ready.
module carregador_matriz (
    input  logic                 clk,
    input  logic                 rst,
    carregador_matriz_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [2:0]           row_q, col_q;
    logic [2:0]           last_idx;
    logic [4:0]           slot;
    logic [7:0]           base;
    logic                 accept;
    logic                 last_elem;
    logic signed [199:0]  frame_q;
    logic [1:0]           size_q;

    // Last valid row/col index is N-1 = size code + 1.
    assign last_idx  = {1'b0, size_q} + 3'd1;
    assign slot      = {2'b00, row_q} * 5'd5 + {2'b00, col_q};
    assign base      = {slot, 3'b000};
    assign accept    = (state_q == LOAD) && bus.in_valid;
    assign last_elem = (row_q == last_idx) && (col_q == last_idx);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) state_d = LOAD;
            end
            LOAD: begin
                bus.in_ready = 1'b1;
                bus.busy     = 1'b1;
                if (accept && last_elem) state_d = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                bus.busy      = 1'b1;
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_q <= '0;
            size_q  <= 2'b00;
            row_q   <= 3'd0;
            col_q   <= 3'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        size_q  <= bus.matrix_size_in;
                        frame_q <= '0;
                        row_q   <= 3'd0;
                        col_q   <= 3'd0;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        frame_q[base +: 8] <= bus.in_data;
                        // Counters park at 0 after the final element so they never exceed 4.
                        if (last_elem) begin
                            row_q <= 3'd0;
                            col_q <= 3'd0;
                        end else if (col_q == last_idx) begin
                            col_q <= 3'd0;
                            row_q <= row_q + 3'd1;
                        end else begin
                            col_q <= col_q + 3'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.matrix_A    = frame_q;
    assign bus.matrix_size = size_q;

endmodule

// File: tb/tb_carregador_matriz.sv
// Directed self-checking bench for carregador_matriz: a table-driven 2x2
// handshake run plus hand-written multi-cycle sequences.
module tb_carregador_matriz;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    carregador_matriz_if bus ();

    carregador_matriz dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       start;
        logic [1:0] size;
        logic       iv;
        logic [7:0] data;
        logic       oready;
        logic       e_ir;
        logic       e_ov;
        logic       e_busy;
        logic       chk_frame;
    } vec_t;

    vec_t vt [17];

    task automatic check(input string name, input logic [199:0] act, input logic [199:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [199:0] exp_frame(input int n, input logic [7:0] first, input logic [7:0] step);
        logic [199:0] f;
        logic [7:0]   v;
        f = '0;
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++) begin
                v = first + step * 8'(r * n + c);
                f[(r * 5 + c) * 8 +: 8] = v;
            end
        return f;
    endfunction

    task automatic idle_inputs();
        bus.start          = 1'b0;
        bus.matrix_size_in = 2'b00;
        bus.in_data        = 8'sd0;
        bus.in_valid       = 1'b0;
        bus.out_ready      = 1'b0;
    endtask

    task automatic do_start(input logic [1:0] size);
        bus.start          = 1'b1;
        bus.matrix_size_in = size;
        tick();
        bus.start          = 1'b0;
        check("in_ready_after_start", 200'(bus.in_ready), 200'd1);
    endtask

    // Sends `count` elements first, first+step, ...; optional stall every third
    // cycle and an optional start pulse (size 11) when element `start_at` is presented.
    task automatic send_elems(input int n, input int count, input logic [7:0] first,
                              input logic [7:0] step, input bit stall, input int start_at);
        int   sent = 0;
        int   cyc  = 0;
        logic acc;
        while (sent < count && cyc < 200) begin
            bus.in_valid       = !(stall && (cyc % 3 == 2));
            bus.in_data        = first + step * 8'(sent);
            bus.start          = (sent == start_at) && bus.in_valid;
            bus.matrix_size_in = 2'b11;
            if (bus.in_valid && sent == n * n - 1)
                check("out_valid_before_last", 200'(bus.out_valid), 200'd0);
            acc = bus.in_valid && bus.in_ready;
            tick();
            cyc++;
            if (acc) sent++;
        end
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        if (sent < count) check("send_timeout", 200'(sent), 200'(count));
        if (count == n * n)
            check("out_valid_after_last", 200'(bus.out_valid), 200'd1);
    endtask

    task automatic release_frame();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("idle_after_release", 200'({bus.busy, bus.out_valid}), 200'd0);
    endtask

    initial begin
        logic [199:0] held;

        // Table for the 2x2 continuous load and 10-cycle hold.
        for (int i = 0; i < 17; i++)
            vt[i] = '{start: 1'b0, size: 2'b00, iv: 1'b0, data: 8'h00, oready: 1'b0,
                      e_ir: 1'b0, e_ov: 1'b1, e_busy: 1'b1, chk_frame: 1'b1};
        vt[0] = '{1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 1; i <= 3; i++)
            vt[i] = '{1'b0, 2'b00, 1'b1, 8'(i), 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vt[4]  = '{1'b0, 2'b00, 1'b1, 8'd4, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        vt[15] = '{1'b0, 2'b00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[16] = '{1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("rst_matrix_A", bus.matrix_A, '0);
        check("rst_out_valid", 200'(bus.out_valid), 200'd0);
        check("rst_in_ready", 200'(bus.in_ready), 200'd0);
        check("rst_busy", 200'(bus.busy), 200'd0);
        check("rst_matrix_size", 200'(bus.matrix_size), 200'd0);

        // 2x2 table run: out_valid appears after edge k+4 (5th cycle from start).
        for (int i = 0; i < 17; i++) begin
            bus.start          = vt[i].start;
            bus.matrix_size_in = vt[i].size;
            bus.in_valid       = vt[i].iv;
            bus.in_data        = vt[i].data;
            bus.out_ready      = vt[i].oready;
            tick();
            check($sformatf("vec%0d_in_ready", i), 200'(bus.in_ready), 200'(vt[i].e_ir));
            check($sformatf("vec%0d_out_valid", i), 200'(bus.out_valid), 200'(vt[i].e_ov));
            check($sformatf("vec%0d_busy", i), 200'(bus.busy), 200'(vt[i].e_busy));
            if (vt[i].chk_frame)
                check($sformatf("vec%0d_frame", i), bus.matrix_A, exp_frame(2, 8'd1, 8'd1));
        end
        idle_inputs();
        check("2x2_size", 200'(bus.matrix_size), 200'd0);

        // 5x5 signed with stalls every third cycle.
        do_start(2'b11);
        send_elems(5, 25, 8'h80, 8'd1, 1'b1, -1);
        check("5x5_frame", bus.matrix_A, exp_frame(5, 8'h80, 8'd1));
        check("5x5_size", 200'(bus.matrix_size), 200'd3);
        release_frame();

        // Prior 0xFF frame, then 3x3 10..18 with a start pulse mid-load.
        do_start(2'b11);
        send_elems(5, 25, 8'hFF, 8'd0, 1'b0, -1);
        check("ff_frame", bus.matrix_A, exp_frame(5, 8'hFF, 8'd0));
        release_frame();
        tick();
        do_start(2'b01);
        send_elems(3, 9, 8'd10, 8'd1, 1'b0, 4);
        check("3x3_frame", bus.matrix_A, exp_frame(3, 8'd10, 8'd1));
        check("3x3_size", 200'(bus.matrix_size), 200'd1);

        // start and in_valid with 0x55 during DONE must be ignored.
        held = bus.matrix_A;
        bus.start          = 1'b1;
        bus.matrix_size_in = 2'b00;
        bus.in_valid       = 1'b1;
        bus.in_data        = 8'sh55;
        tick();
        tick();
        idle_inputs();
        check("done_hold_frame", bus.matrix_A, held);
        check("done_hold_valid", 200'(bus.out_valid), 200'd1);
        check("done_hold_size", 200'(bus.matrix_size), 200'd1);
        release_frame();

        // Reset after 2 of 9 elements of a 3x3 load.
        do_start(2'b01);
        send_elems(3, 2, 8'h21, 8'd1, 1'b0, -1);
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'sh77;
        tick();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        check("midrst_frame", bus.matrix_A, '0);
        check("midrst_busy", 200'(bus.busy), 200'd0);
        check("midrst_in_ready", 200'(bus.in_ready), 200'd0);
        check("midrst_size", 200'(bus.matrix_size), 200'd0);
        tick();
        do_start(2'b00);
        send_elems(2, 4, 8'h7F, 8'h11, 1'b0, -1);
        check("post_rst_frame", bus.matrix_A, exp_frame(2, 8'h7F, 8'h11));
        check("post_rst_size", 200'(bus.matrix_size), 200'd0);
        release_frame();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
